// File: rtl/fetch_sequencer.sv
// Two-byte instruction fetch sequencer: reads low then high byte through the PC
// of the address register file, presents the 16-bit instruction, and handles jumps and timeouts.
module fetch_sequencer #(
   parameter int TIMEOUT = 15
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic        halt,
   input  logic        mem_ready,
   input  logic [7:0]  mem_data,
   input  logic        ir_ack,
   input  logic        jump,
   input  logic [7:0]  jump_addr,
   output logic        mem_rd,
   output logic [1:0]  arf_oasel,
   output logic [3:0]  arf_rsel,
   output logic [1:0]  arf_funsel,
   output logic [7:0]  arf_input,
   output logic [15:0] ir,
   output logic        ir_valid,
   output logic        busy,
   output logic        err
);

   typedef enum logic [2:0] {
      IDLE,
      REQ_LO,
      REQ_HI,
      VALID,
      ERROR
   } state_t;

   localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT);

   state_t     state;
   logic [7:0] wait_cnt;

   // State, instruction register and wait counter; the counter restarts whenever a byte request begins.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         wait_cnt <= 8'h00;
         ir       <= 16'h0000;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= REQ_LO;
                  wait_cnt <= 8'h00;
               end
            end
            REQ_LO: begin
               if (mem_ready) begin
                  ir[7:0]  <= mem_data;
                  state    <= REQ_HI;
                  wait_cnt <= 8'h00;
               end else if (wait_cnt == TIMEOUT_VAL) begin
                  state <= ERROR;
               end else begin
                  wait_cnt <= wait_cnt + 8'h01;
               end
            end
            REQ_HI: begin
               if (mem_ready) begin
                  ir[15:8] <= mem_data;
                  state    <= VALID;
               end else if (wait_cnt == TIMEOUT_VAL) begin
                  state <= ERROR;
               end else begin
                  wait_cnt <= wait_cnt + 8'h01;
               end
            end
            VALID: begin
               if (ir_ack) begin
                  state    <= halt ? IDLE : REQ_LO;
                  wait_cnt <= 8'h00;
               end
            end
            ERROR: begin
               if (start) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Status and read strobes follow the state alone; the ARF write strobes fire in the
   // same cycle as the capture or jump they accompany.
   always_comb begin
      mem_rd     = 1'b0;
      arf_oasel  = 2'b00;
      arf_rsel   = 4'b0000;
      arf_funsel = 2'b00;
      arf_input  = 8'h00;
      ir_valid   = 1'b0;
      busy       = 1'b0;
      err        = 1'b0;
      case (state)
         REQ_LO, REQ_HI: begin
            mem_rd    = 1'b1;
            arf_oasel = 2'b11;
            busy      = 1'b1;
            if (mem_ready) begin
               arf_rsel   = 4'b1000;
               arf_funsel = 2'b11;
            end
         end
         VALID: begin
            ir_valid = 1'b1;
            busy     = 1'b1;
            if (ir_ack && jump) begin
               arf_rsel   = 4'b1000;
               arf_funsel = 2'b01;
               arf_input  = jump_addr;
            end
         end
         ERROR: err = 1'b1;
         default: ;
      endcase
   end

endmodule
